// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key-schedule constants, FSM state encoding and the
// round-key stream response record used by aes_key_sched_ctrl.
//   NB/NK/NR     - words per block, words per key, number of rounds
//   EXP_CYCLES   - rising edges KeyExpansion needs after its reset is released
//   RK_W/KEY_W   - round-key and cipher-key widths
//   SCHED_W      - width of the full expanded schedule (round 0 in MSBs)
package aes_pkg;

  localparam int NB         = 4;
  localparam int NK         = 4;
  localparam int NR         = 10;
  localparam int EXP_CYCLES = NB*(NR+1)-(NK-1);   // 41

  localparam int RK_W    = 32*NB;                 // 128
  localparam int KEY_W   = 32*NK;                 // 128
  localparam int SCHED_W = RK_W*(NR+1);           // 1408

  localparam int IDX_W = 4;
  localparam int CNT_W = $clog2(EXP_CYCLES);      // 6

  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NR);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXP_CYCLES-1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXPAND,
    READY,
    STREAM
  } state_e;

  // One beat of the round-key stream as it leaves the controller.
  typedef struct packed {
    logic             valid;
    logic             last;
    logic [IDX_W-1:0] index;
    logic [RK_W-1:0]  data;
  } rk_rsp_t;

endpackage

// File: rtl/round_key_select.sv
// round_key_select: combinational pick of one round key out of the expanded
// schedule. The caller registers the result.
//   keys_i - full schedule, round 0 in the MSBs
//   idx_i  - round number 0..NR; anything larger selects zero
//   rk_o   - selected round key
module round_key_select
  import aes_pkg::*;
(
  input  logic [SCHED_W-1:0] keys_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [RK_W-1:0]    rk_o
);

  // Element [NR] of the packed view holds the MSBs, i.e. round 0.
  logic [NR:0][RK_W-1:0] keys_arr;

  assign keys_arr = keys_i;

  always_comb begin
    rk_o = '0;
    for (int i = 0; i <= NR; i++) begin
      if (idx_i == IDX_W'(i)) rk_o = keys_arr[NR-i];
    end
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: sequences an external AES-128 KeyExpansion block and
// streams its round keys to the cipher round core.
//   clk, reset_n      - single clock, synchronous active-low reset
//   key_valid/key_data/key_ready - cipher key load handshake
//   ke_reset_n, ke_key_in        - registered controls to KeyExpansion
//   ke_round_keys                - expanded schedule back from KeyExpansion
//   rk_req, rk_dir               - start a stream (0: rounds 0..NR, 1: NR..0)
//   rk_valid/rk_data/rk_index/rk_last - registered round-key stream
//   keys_ready                   - schedule is valid for the loaded key
// KeyExpansion lives beside this block so another consumer can share it.
module aes_key_sched_ctrl
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               key_valid,
  input  logic [KEY_W-1:0]   key_data,
  output logic               key_ready,
  output logic               ke_reset_n,
  output logic [KEY_W-1:0]   ke_key_in,
  input  logic [SCHED_W-1:0] ke_round_keys,
  input  logic               rk_req,
  input  logic               rk_dir,
  output logic               rk_valid,
  output logic [RK_W-1:0]    rk_data,
  output logic [IDX_W-1:0]   rk_index,
  output logic               rk_last,
  output logic               keys_ready
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               dir_q;
  logic               ke_rst_n_q;
  logic [KEY_W-1:0]   ke_key_q;
  logic               keys_rdy_q;
  rk_rsp_t            rk_q;

  logic [IDX_W-1:0]   start_idx;
  logic [IDX_W-1:0]   idx_nxt;
  logic [IDX_W-1:0]   stream_end;
  logic [IDX_W-1:0]   sel_idx;
  logic [RK_W-1:0]    sel_rk;

  // rk_q.index doubles as the stream position counter.
  assign start_idx  = rk_dir ? IDX_MAX : '0;
  assign idx_nxt    = dir_q ? (rk_q.index - IDX_W'(1)) : (rk_q.index + IDX_W'(1));
  assign stream_end = dir_q ? '0 : IDX_MAX;

  // Look up the key that will be presented after the coming edge: the first
  // key of a new stream from READY, the next step while streaming.
  assign sel_idx = (state_q == STREAM) ? idx_nxt : start_idx;

  round_key_select u_sel (
    .keys_i (ke_round_keys),
    .idx_i  (sel_idx),
    .rk_o   (sel_rk)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      ke_rst_n_q <= 1'b0;
      ke_key_q   <= '0;
      keys_rdy_q <= 1'b0;
      rk_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_valid) begin
            ke_key_q   <= key_data;
            ke_rst_n_q <= 1'b0;
            state_q    <= LOAD;
          end
        end

        // Single cycle with KeyExpansion held in reset on the new key.
        LOAD: begin
          ke_rst_n_q <= 1'b1;
          cnt_q      <= CNT_LOAD;
          state_q    <= EXPAND;
        end

        EXPAND: begin
          if (cnt_q == '0) begin
            keys_rdy_q <= 1'b1;
            state_q    <= READY;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        // A new key wins over a stream request arriving in the same cycle.
        READY: begin
          if (key_valid) begin
            ke_key_q   <= key_data;
            ke_rst_n_q <= 1'b0;
            keys_rdy_q <= 1'b0;
            state_q    <= LOAD;
          end else if (rk_req) begin
            dir_q      <= rk_dir;
            rk_q.valid <= 1'b1;
            rk_q.last  <= 1'b0;
            rk_q.index <= start_idx;
            rk_q.data  <= sel_rk;
            state_q    <= STREAM;
          end
        end

        // No backpressure: one key per cycle, back to READY after the last.
        STREAM: begin
          if (rk_q.last) begin
            rk_q.valid <= 1'b0;
            rk_q.last  <= 1'b0;
            state_q    <= READY;
          end else begin
            rk_q.index <= idx_nxt;
            rk_q.data  <= sel_rk;
            rk_q.last  <= (idx_nxt == stream_end);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Decoded from state only, so no input-to-output path.
  assign key_ready  = (state_q == IDLE) || (state_q == READY);

  assign ke_reset_n = ke_rst_n_q;
  assign ke_key_in  = ke_key_q;
  assign keys_ready = keys_rdy_q;
  assign rk_valid   = rk_q.valid;
  assign rk_last    = rk_q.last;
  assign rk_index   = rk_q.index;
  assign rk_data    = rk_q.data;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl. A small KeyExpansion stand-in
// presents the schedule only once 41 edges have passed with ke_reset_n high.
// K1 uses the FIPS-197 A.1 schedule; K2 has reference rounds 0 and 10 and
// per-round tag patterns in between.
module tb_aes_key_sched_ctrl;
  import aes_pkg::*;

  logic               clk;
  logic               reset_n;
  logic               key_valid;
  logic [KEY_W-1:0]   key_data;
  logic               key_ready;
  logic               ke_reset_n;
  logic [KEY_W-1:0]   ke_key_in;
  logic [SCHED_W-1:0] ke_round_keys;
  logic               rk_req;
  logic               rk_dir;
  logic               rk_valid;
  logic [RK_W-1:0]    rk_data;
  logic [IDX_W-1:0]   rk_index;
  logic               rk_last;
  logic               keys_ready;

  int errs;
  int checks;

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2     = 128'hcbae1d16384e56a69b07111e3f2aeffa;
  localparam logic [127:0] K2_R10 = 128'h651f9e7c9ad260e70845dbeece7da0cc;

  localparam logic [127:0] K1_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  aes_key_sched_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .key_valid     (key_valid),
    .key_data      (key_data),
    .key_ready     (key_ready),
    .ke_reset_n    (ke_reset_n),
    .ke_key_in     (ke_key_in),
    .ke_round_keys (ke_round_keys),
    .rk_req        (rk_req),
    .rk_dir        (rk_dir),
    .rk_valid      (rk_valid),
    .rk_data       (rk_data),
    .rk_index      (rk_index),
    .rk_last       (rk_last),
    .keys_ready    (keys_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- KeyExpansion stand-in ----------------
  int ke_cnt;

  always @(posedge clk) begin
    if (!ke_reset_n) ke_cnt <= 0;
    else if (ke_cnt < EXP_CYCLES) ke_cnt <= ke_cnt + 1;
  end

  function automatic logic [127:0] ref_rk(input logic [127:0] k, input int r);
    logic [7:0] tag;
    tag = 8'(8'h50 + r);
    if (k == K1) return K1_RK[r];
    if (r == 0) return k;
    if (r == NR) return K2_R10;
    return {16{tag}};
  endfunction

  always_comb begin
    ke_round_keys = '0;
    if (ke_cnt == EXP_CYCLES) begin
      for (int r = 0; r <= NR; r++)
        ke_round_keys[SCHED_W-1-RK_W*r -: RK_W] = ref_rk(ke_key_in, r);
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a key in IDLE/READY and measure the edges until keys_ready.
  task automatic do_load(input logic [127:0] k);
    int n;
    key_valid = 1'b1;
    key_data  = k;
    step();
    key_valid = 1'b0;
    checks++;
    if (key_ready !== 1'b0) begin errs++; $display("FAIL load_key_ready: got %b exp 0", key_ready); end
    checks++;
    if (ke_reset_n !== 1'b0) begin errs++; $display("FAIL load_ke_reset_n: got %b exp 0", ke_reset_n); end
    checks++;
    if (ke_key_in !== k) begin errs++; $display("FAIL load_ke_key_in: got %h exp %h", ke_key_in, k); end
    n = 0;
    while (n < 60) begin
      step();
      n++;
      if (keys_ready === 1'b1) break;
    end
    checks++;
    if (n != 42) begin errs++; $display("FAIL keys_ready_latency: got %0d exp 42", n); end
    checks++;
    if (ke_reset_n !== 1'b1) begin errs++; $display("FAIL expand_ke_reset_n: got %b exp 1", ke_reset_n); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; key_valid = 1'b0; key_data = '0; rk_req = 1'b0; rk_dir = 1'b0;
    repeat (3) step();
    checks++;
    if (key_ready !== 1'b1) begin errs++; $display("FAIL rst_key_ready: got %b exp 1", key_ready); end
    checks++;
    if (ke_reset_n !== 1'b0) begin errs++; $display("FAIL rst_ke_reset_n: got %b exp 0", ke_reset_n); end
    checks++;
    if (ke_key_in !== '0) begin errs++; $display("FAIL rst_ke_key_in: got %h exp 0", ke_key_in); end
    checks++;
    if (keys_ready !== 1'b0) begin errs++; $display("FAIL rst_keys_ready: got %b exp 0", keys_ready); end
    checks++;
    if (rk_valid !== 1'b0) begin errs++; $display("FAIL rst_rk_valid: got %b exp 0", rk_valid); end
    checks++;
    if (rk_data !== '0) begin errs++; $display("FAIL rst_rk_data: got %h exp 0", rk_data); end
    checks++;
    if (rk_index !== '0) begin errs++; $display("FAIL rst_rk_index: got %0d exp 0", rk_index); end
    checks++;
    if (rk_last !== 1'b0) begin errs++; $display("FAIL rst_rk_last: got %b exp 0", rk_last); end
    reset_n = 1'b1;
    step();
    checks++;
    if (key_ready !== 1'b1) begin errs++; $display("FAIL idle_key_ready: got %b exp 1", key_ready); end
  endtask

  task automatic test_encrypt();
    logic [IDX_W-1:0] ei;
    do_load(K1);
    rk_req = 1'b1; rk_dir = 1'b0;
    step();
    rk_req = 1'b0;
    for (int i = 0; i <= NR; i++) begin
      ei = IDX_W'(i);
      checks++;
      if (rk_valid !== 1'b1) begin errs++; $display("FAIL enc_valid[%0d]: got %b exp 1", i, rk_valid); end
      checks++;
      if (rk_index !== ei) begin errs++; $display("FAIL enc_index[%0d]: got %0d exp %0d", i, rk_index, ei); end
      checks++;
      if (rk_data !== K1_RK[i]) begin errs++; $display("FAIL enc_data[%0d]: got %h exp %h", i, rk_data, K1_RK[i]); end
      checks++;
      if (rk_last !== (i == NR)) begin errs++; $display("FAIL enc_last[%0d]: got %b exp %b", i, rk_last, (i == NR)); end
      step();
    end
    checks++;
    if (rk_valid !== 1'b0) begin errs++; $display("FAIL enc_end_valid: got %b exp 0", rk_valid); end
    checks++;
    if (keys_ready !== 1'b1 || key_ready !== 1'b1) begin
      errs++; $display("FAIL enc_end_ready: got keys_ready=%b key_ready=%b exp 1/1", keys_ready, key_ready);
    end
  endtask

  task automatic test_decrypt();
    logic [IDX_W-1:0] ei;
    rk_req = 1'b1; rk_dir = 1'b1;
    step();
    rk_req = 1'b0; rk_dir = 1'b0;
    for (int i = 0; i <= NR; i++) begin
      ei = IDX_W'(NR - i);
      checks++;
      if (rk_index !== ei) begin errs++; $display("FAIL dec_index[%0d]: got %0d exp %0d", i, rk_index, ei); end
      checks++;
      if (rk_data !== K1_RK[NR-i]) begin errs++; $display("FAIL dec_data[%0d]: got %h exp %h", i, rk_data, K1_RK[NR-i]); end
      checks++;
      if (rk_last !== (i == NR)) begin errs++; $display("FAIL dec_last[%0d]: got %b exp %b", i, rk_last, (i == NR)); end
      checks++;
      if (keys_ready !== 1'b1) begin errs++; $display("FAIL dec_keys_ready[%0d]: got %b exp 1", i, keys_ready); end
      step();
    end
    checks++;
    if (rk_valid !== 1'b0) begin errs++; $display("FAIL dec_end_valid: got %b exp 0", rk_valid); end
  endtask

  task automatic test_back_to_back();
    logic [IDX_W-1:0] ei;
    rk_req = 1'b1; rk_dir = 1'b0;
    step();
    for (int i = 0; i <= NR; i++) begin
      ei = IDX_W'(i);
      checks++;
      if (rk_valid !== 1'b1 || rk_index !== ei) begin
        errs++; $display("FAIL b2b_first[%0d]: got valid=%b index=%0d exp 1/%0d", i, rk_valid, rk_index, ei);
      end
      step();
    end
    checks++;
    if (rk_valid !== 1'b0) begin errs++; $display("FAIL b2b_gap: got %b exp 0", rk_valid); end
    step();
    rk_req = 1'b0;
    checks++;
    if (rk_valid !== 1'b1 || rk_index !== 4'd0 || rk_data !== K1_RK[0]) begin
      errs++; $display("FAIL b2b_restart: got valid=%b index=%0d data=%h", rk_valid, rk_index, rk_data);
    end
    repeat (11) step();
    checks++;
    if (rk_valid !== 1'b0) begin errs++; $display("FAIL b2b_end_valid: got %b exp 0", rk_valid); end
  endtask

  // key_valid and rk_req (with a flipped rk_dir) held through a whole stream.
  task automatic test_ignored_stream();
    logic [IDX_W-1:0] ei;
    rk_req = 1'b1; rk_dir = 1'b0;
    step();
    rk_dir = 1'b1; key_valid = 1'b1; key_data = K2;
    for (int i = 0; i <= NR; i++) begin
      ei = IDX_W'(i);
      checks++;
      if (rk_valid !== 1'b1 || rk_index !== ei) begin
        errs++; $display("FAIL ign_stream_index[%0d]: got valid=%b index=%0d exp 1/%0d", i, rk_valid, rk_index, ei);
      end
      checks++;
      if (key_ready !== 1'b0 || ke_key_in !== K1) begin
        errs++; $display("FAIL ign_stream_key[%0d]: got key_ready=%b ke_key_in=%h", i, key_ready, ke_key_in);
      end
      if (i == NR) begin
        rk_req = 1'b0; key_valid = 1'b0; rk_dir = 1'b0;
      end
      step();
    end
    checks++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      errs++; $display("FAIL ign_stream_end: got valid=%b key_ready=%b exp 0/1", rk_valid, key_ready);
    end
  endtask

  // New key in READY alongside rk_req, then requests held through expansion.
  task automatic test_key_change();
    int n;
    logic saw_valid;
    key_valid = 1'b1; key_data = K2; rk_req = 1'b1; rk_dir = 1'b0;
    step();
    key_data = K1;
    checks++;
    if (rk_valid !== 1'b0) begin errs++; $display("FAIL kc_no_stream: got %b exp 0", rk_valid); end
    checks++;
    if (keys_ready !== 1'b0) begin errs++; $display("FAIL kc_keys_ready_drop: got %b exp 0", keys_ready); end
    checks++;
    if (ke_key_in !== K2) begin errs++; $display("FAIL kc_ke_key_in: got %h exp %h", ke_key_in, K2); end
    n = 0;
    saw_valid = 1'b0;
    while (n < 60) begin
      step();
      n++;
      if (rk_valid !== 1'b0) saw_valid = 1'b1;
      if (keys_ready === 1'b1) break;
    end
    key_valid = 1'b0; rk_req = 1'b0;
    checks++;
    if (n != 42) begin errs++; $display("FAIL kc_latency: got %0d exp 42", n); end
    checks++;
    if (saw_valid !== 1'b0) begin errs++; $display("FAIL kc_ignored_req: got rk_valid seen=%b exp 0", saw_valid); end
    checks++;
    if (ke_key_in !== K2) begin errs++; $display("FAIL kc_ignored_key: got %h exp %h", ke_key_in, K2); end
    rk_req = 1'b1; rk_dir = 1'b1;
    step();
    rk_req = 1'b0; rk_dir = 1'b0;
    checks++;
    if (rk_index !== 4'd10 || rk_data !== K2_R10) begin
      errs++; $display("FAIL kc_round10: got index=%0d data=%h exp 10/%h", rk_index, rk_data, K2_R10);
    end
    repeat (11) step();
    checks++;
    if (rk_valid !== 1'b0) begin errs++; $display("FAIL kc_end_valid: got %b exp 0", rk_valid); end
  endtask

  task automatic test_reset_mid_stream();
    rk_req = 1'b1; rk_dir = 1'b0;
    step();
    rk_req = 1'b0;
    repeat (5) step();
    checks++;
    if (rk_index !== 4'd5 || rk_data !== ref_rk(K2, 5)) begin
      errs++; $display("FAIL mid_round5: got index=%0d data=%h", rk_index, rk_data);
    end
    reset_n = 1'b0;
    step();
    checks++;
    if (rk_valid !== 1'b0 || rk_index !== 4'd0 || rk_last !== 1'b0) begin
      errs++; $display("FAIL mid_rst_stream: got valid=%b index=%0d last=%b exp 0/0/0", rk_valid, rk_index, rk_last);
    end
    checks++;
    if (keys_ready !== 1'b0 || key_ready !== 1'b1) begin
      errs++; $display("FAIL mid_rst_state: got keys_ready=%b key_ready=%b exp 0/1", keys_ready, key_ready);
    end
    checks++;
    if (ke_reset_n !== 1'b0 || ke_key_in !== '0) begin
      errs++; $display("FAIL mid_rst_ke: got ke_reset_n=%b ke_key_in=%h exp 0/0", ke_reset_n, ke_key_in);
    end
    reset_n = 1'b1;
    repeat (3) step();
    checks++;
    if (rk_valid !== 1'b0 || keys_ready !== 1'b0) begin
      errs++; $display("FAIL mid_rst_abandon: got valid=%b keys_ready=%b exp 0/0", rk_valid, keys_ready);
    end
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_back_to_back();
    test_ignored_stream();
    test_key_change();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Controller that sequences the AES-128 `KeyExpansion` datapath and serves its round keys to the cipher round core. It accepts a new cipher key over a valid/ready handshake and restarts `KeyExpansion` with a one-cycle reset pulse. It waits the fixed expansion latency, then streams the Nr+1 round keys one per cycle in encrypt order or decrypt order on request. It sits between the key-load interface and the `KeyExpansion` / cipher-round pair.

## Interface
- Nb, 4, words per block
- Nk, 4, words per key
- Nr, 10, number of rounds
- EXP_CYCLES, Nb*(Nr+1)-(Nk-1) = 41, rising edges `KeyExpansion` needs after reset release

- clk  in  1  clock; single clock domain
- reset_n  in  1  synchronous, active-low reset
- key_valid  in  1  new key offered
- key_data  in  32*Nk  cipher key, word 0 in MSBs
- key_ready  out  1  controller can accept a key
- ke_reset_n  out  1  registered reset to `KeyExpansion`
- ke_key_in  out  32*Nk  registered key to `KeyExpansion`
- ke_round_keys  in  32*Nb*(Nr+1)  expanded schedule; round 0 in MSBs
- rk_req  in  1  start a round-key stream
- rk_dir  in  1  0 = rounds 0..Nr; 1 = rounds Nr..0
- rk_valid  out  1  rk_data valid this cycle
- rk_data  out  32*Nb  round key
- rk_index  out  4  round number of rk_data
- rk_last  out  1  final key of the stream
- keys_ready  out  1  schedule valid for the current key

## Operation
- FSM states: IDLE, LOAD, EXPAND, READY, STREAM.
- IDLE: key_ready=1. On key_valid, latch key_data into ke_key_in and go to LOAD.
- LOAD: lasts one cycle with ke_reset_n=0. Load cnt=EXP_CYCLES-1, then go to EXPAND.
- EXPAND: ke_reset_n=1. cnt decrements each edge. At the edge where cnt==0, go to READY.
- READY: keys_ready=1 and key_ready=1.
  - key_valid has priority: latch the key, go to LOAD, drop keys_ready, and ignore rk_req that cycle.
  - Otherwise, on rk_req, latch rk_dir, set idx=0 (dir 0) or idx=Nr (dir 1), and go to STREAM.
- STREAM: rk_valid=1 and rk_index=idx.
  - rk_data = ke_round_keys[W-1-128*idx -: 128], where W = 32*Nb*(Nr+1).
  - idx steps +1 (dir 0) or -1 (dir 1) each cycle.
  - rk_last=1 when idx==Nr (dir 0) or idx==0 (dir 1), then return to READY.
  - key_ready=0. rk_req is ignored. There is no backpressure.
- rk_req in IDLE, LOAD or EXPAND is ignored (not queued).
- key_valid while key_ready=0 is not accepted; the source holds it.
- keys_ready stays 1 through STREAM.
- idx and cnt never wrap: idx stays in 0..Nr and cnt in 0..EXP_CYCLES-1.

## Timing
- Reset values: state IDLE, key_ready=1, ke_reset_n=0, ke_key_in=0, keys_ready=0, rk_valid=0, rk_data=0, rk_index=0, rk_last=0.
- Reset mid-operation: reset_n low at any state forces all of the above on the next edge, including mid-STREAM. Any partial stream is abandoned.
- All outputs are registered except key_ready, which decodes state only and has no combinational path from inputs.
- Key-to-ready latency: keys_ready rises 42 cycles after the accepting edge (1 LOAD + 41 EXPAND).
- Stream latency: the first rk_valid appears the cycle after the rk_req edge. Nr+1 consecutive valid cycles follow, and the next cycle is READY.
- Back-to-back streams: rk_req held high restarts a stream on the cycle after rk_last, giving a one-cycle gap.

## Structure
- Shared package `aes_pkg`: Nb, Nk, Nr, EXP_CYCLES, the FSM state enum, and the round-key width (128).
- Sub-module `round_key_select`: combinational slice of ke_round_keys by index, registered in the parent.
- `KeyExpansion` is instanced beside this block, not inside it, so a second consumer can share it.

## Test plan
- Reset: hold reset_n=0 for 3 cycles, then release. Required: all outputs at reset values, key_ready=1.
- Encrypt stream:
  - Load 2b7e151628aed2a6abf7158809cf4f3c. Required: keys_ready high exactly 42 cycles after acceptance.
  - Issue rk_req with rk_dir=0. Required:
    - Round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
    - Round 1 = a0fafe1788542cb123a339392a6c7605.
    - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with rk_last=1.
- Decrypt stream: same key, rk_dir=1. Required: first output rk_index=10, data d014f9a8…0ca6. Last output rk_index=0, data 2b7e1516…4f3c, with rk_last=1.
- Key change in READY: load cbae1d16384e56a69b07111e3f2aeffa with rk_req asserted in the same cycle. Required:
  - No stream starts and keys_ready drops.
  - After 42 cycles, round 10 = 651f9e7c9ad260e70845dbeece7da0cc.
- Ignored requests: assert key_valid and rk_req during EXPAND and STREAM. Required: no acceptance, no stream restart, and no glitch on rk_index.
- Reset mid-STREAM at round 5. Required: rk_valid=0 and state IDLE on the next edge, and keys_ready=0.
